// File: rtl/shutdown_ctrl.sv
// shutdown_ctrl
// Tears the design down in reverse power-up order: processor, then the RS232
// path, then the clock generator. An orderly teardown starts from a shutdown
// request. A filtered PLL lock loss skips the hold and drain waits. Every
// output only ever asserts, because the outputs are ORed with the power-up
// sequencer's resets. Only reset_n clears them again.
module shutdown_ctrl #(
  parameter int unsigned HOLD_TIMEOUT  = 255,
  parameter int unsigned PROC_CNT      = 16,
  parameter int unsigned DRAIN_TIMEOUT = 255,
  parameter int unsigned RS232_CNT     = 64,
  parameter int unsigned CLKGEN_CNT    = 16,
  parameter int unsigned LOCK_FILT     = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_shutdown_req,
  input  logic i_locked_proc1,
  input  logic i_locked_rs232,
  input  logic i_proc1_idle,
  input  logic i_rs232_tx_idle,
  output logic o_hold_proc1,
  output logic o_reset_proc1,
  output logic o_reset_rs232,
  output logic o_reset_clkgen,
  output logic o_shutdown_ack,
  output logic o_lock_lost,
  output logic o_timeout
);

  typedef enum logic [6:0] {
    S_RUNNING      = 7'b0000001,
    S_HOLD_PROC    = 7'b0000010,
    S_RESET_PROC   = 7'b0000100,
    S_DRAIN_RS232  = 7'b0001000,
    S_RESET_RS232  = 7'b0010000,
    S_RESET_CLKGEN = 7'b0100000,
    S_DONE         = 7'b1000000
  } state_t;

  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_TIMEOUT - 1);
  localparam logic [7:0] PROC_LAST   = 8'(PROC_CNT - 1);
  localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [7:0] RS232_LAST  = 8'(RS232_CNT - 1);
  localparam logic [7:0] CLKGEN_LAST = 8'(CLKGEN_CNT - 1);
  localparam logic [7:0] FILT_LAST   = 8'(LOCK_FILT - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_count;
  logic [7:0] w_nextCount;
  logic [7:0] r_lockCnt;
  logic [7:0] w_nextLockCnt;
  logic       r_armed;
  logic       w_nextArmed;
  logic       w_allLocked;
  logic       w_lockLoss;
  logic       w_waitExpired;

  logic       w_nextHold;
  logic       w_nextResetProc;
  logic       w_nextResetRs232;
  logic       w_nextResetClkgen;
  logic       w_nextAck;
  logic       w_nextLockLost;
  logic       w_nextTimeout;

  assign w_allLocked = i_locked_proc1 & i_locked_rs232;

  // State register together with the shared counter, arming flag and lock filter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_RUNNING;
      r_count   <= '0;
      r_lockCnt <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_count   <= w_nextCount;
      r_lockCnt <= w_nextLockCnt;
      r_armed   <= w_nextArmed;
    end
  end

  // Next-state logic. The counter restarts from zero whenever the state changes.
  always_comb begin
    w_nextState   = r_state;
    w_nextCount   = r_count + 8'd1;
    w_nextLockCnt = r_lockCnt;
    w_nextArmed   = r_armed | w_allLocked;
    w_lockLoss    = 1'b0;
    w_waitExpired = 1'b0;
    case (r_state)
      S_RUNNING: begin
        w_nextCount = '0;
        if (r_armed) begin
          if (w_allLocked) begin
            w_nextLockCnt = '0;
          end else if (r_lockCnt >= FILT_LAST) begin
            w_lockLoss = 1'b1;
          end else begin
            w_nextLockCnt = r_lockCnt + 8'd1;
          end
        end
        if (w_lockLoss) begin
          w_nextState = S_RESET_PROC;
        end else if (i_shutdown_req) begin
          w_nextState = S_HOLD_PROC;
        end
      end
      S_HOLD_PROC: begin
        if (i_proc1_idle) begin
          w_nextState = S_RESET_PROC;
        end else if (r_count == HOLD_LAST) begin
          w_waitExpired = 1'b1;
          w_nextState   = S_RESET_PROC;
        end
      end
      S_RESET_PROC: begin
        if (r_count == PROC_LAST) begin
          w_nextState = o_lock_lost ? S_RESET_RS232 : S_DRAIN_RS232;
        end
      end
      S_DRAIN_RS232: begin
        if (i_rs232_tx_idle) begin
          w_nextState = S_RESET_RS232;
        end else if (r_count == DRAIN_LAST) begin
          w_waitExpired = 1'b1;
          w_nextState   = S_RESET_RS232;
        end
      end
      S_RESET_RS232: begin
        if (r_count == RS232_LAST) begin
          w_nextState = S_RESET_CLKGEN;
        end
      end
      S_RESET_CLKGEN: begin
        if (r_count == CLKGEN_LAST) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextCount = r_count;
      end
      default: begin
        w_nextState = S_RUNNING;
      end
    endcase
    if (w_nextState != r_state) begin
      w_nextCount = '0;
    end
  end

  // Output next-values. Each output sets when its state is entered and then holds.
  always_comb begin
    w_nextHold        = o_hold_proc1   | (w_nextState == S_HOLD_PROC);
    w_nextResetProc   = o_reset_proc1  | (w_nextState == S_RESET_PROC);
    w_nextResetRs232  = o_reset_rs232  | (w_nextState == S_RESET_RS232);
    w_nextResetClkgen = o_reset_clkgen | (w_nextState == S_RESET_CLKGEN);
    w_nextAck         = o_shutdown_ack | (w_nextState == S_DONE);
    w_nextLockLost    = o_lock_lost    | w_lockLoss;
    w_nextTimeout     = o_timeout      | w_waitExpired;
  end

  // Registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_hold_proc1   <= 1'b0;
      o_reset_proc1  <= 1'b0;
      o_reset_rs232  <= 1'b0;
      o_reset_clkgen <= 1'b0;
      o_shutdown_ack <= 1'b0;
      o_lock_lost    <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      o_hold_proc1   <= w_nextHold;
      o_reset_proc1  <= w_nextResetProc;
      o_reset_rs232  <= w_nextResetRs232;
      o_reset_clkgen <= w_nextResetClkgen;
      o_shutdown_ack <= w_nextAck;
      o_lock_lost    <= w_nextLockLost;
      o_timeout      <= w_nextTimeout;
    end
  end

endmodule

// File: tb/tb_shutdown_ctrl.sv
// tb_shutdown_ctrl
// Directed stimulus for shutdown_ctrl. A timestamp model records the clock
// edge at which each output must rise. Every cycle, the DUT outputs are
// compared against that model.
module tb_shutdown_ctrl;

  localparam int HOLD_TIMEOUT  = 255;
  localparam int PROC_CNT      = 16;
  localparam int DRAIN_TIMEOUT = 255;
  localparam int RS232_CNT     = 64;
  localparam int CLKGEN_CNT    = 16;
  localparam int LOCK_FILT     = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic shutdown_req = 1'b0;
  logic locked_proc1 = 1'b0;
  logic locked_rs232 = 1'b0;
  logic proc1_idle = 1'b0;
  logic rs232_tx_idle = 1'b0;
  logic hold_proc1, reset_proc1, reset_rs232, reset_clkgen;
  logic shutdown_ack, lock_lost, timeout;

  int checks = 0;
  int failures = 0;

  // Model state: edge count since reset and the edges at which outputs rise (-1 = not yet)
  int cyc = 0;
  int unlockRun = 0;
  bit mArmed = 0;
  bit mLockLost = 0;
  bit mTimeout = 0;
  int tHold = -1;
  int tProc = -1;
  int tRs = -1;
  int tClk = -1;
  int tAck = -1;

  shutdown_ctrl #(
    .HOLD_TIMEOUT (HOLD_TIMEOUT),
    .PROC_CNT     (PROC_CNT),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
    .RS232_CNT    (RS232_CNT),
    .CLKGEN_CNT   (CLKGEN_CNT),
    .LOCK_FILT    (LOCK_FILT)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_shutdown_req (shutdown_req),
    .i_locked_proc1 (locked_proc1),
    .i_locked_rs232 (locked_rs232),
    .i_proc1_idle   (proc1_idle),
    .i_rs232_tx_idle(rs232_tx_idle),
    .o_hold_proc1   (hold_proc1),
    .o_reset_proc1  (reset_proc1),
    .o_reset_rs232  (reset_rs232),
    .o_reset_clkgen (reset_clkgen),
    .o_shutdown_ack (shutdown_ack),
    .o_lock_lost    (lock_lost),
    .o_timeout      (timeout)
  );

  always #5 clk = ~clk;

  function automatic bit reached(int t);
    return (t >= 0) && (cyc >= t);
  endfunction

  function automatic logic [6:0] dutVec();
    return {hold_proc1, reset_proc1, reset_rs232, reset_clkgen, shutdown_ack, lock_lost, timeout};
  endfunction

  function automatic logic [6:0] modelVec();
    return {reached(tHold), reached(tProc), reached(tRs), reached(tClk), reached(tAck),
            mLockLost, mTimeout};
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(bit req, bit lp, bit lr, bit pidle, bit tidle, int cycles);
    shutdown_req  = req;
    locked_proc1  = lp;
    locked_rs232  = lr;
    proc1_idle    = pidle;
    rs232_tx_idle = tidle;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 3);
    reset_n = 1'b1;
  endtask

  // Timestamp model: on each edge, decide which milestone that edge triggers.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0; unlockRun = 0; mArmed = 0; mLockLost = 0; mTimeout = 0;
      tHold = -1; tProc = -1; tRs = -1; tClk = -1; tAck = -1;
    end else begin
      bit allLocked;
      cyc++;
      allLocked = locked_proc1 && locked_rs232;
      if (tHold < 0 && tProc < 0) begin
        if (mArmed && !allLocked) unlockRun++;
        else unlockRun = 0;
        if (mArmed && unlockRun >= LOCK_FILT) begin
          mLockLost = 1;
          tProc = cyc;
          tRs = cyc + PROC_CNT;
        end else if (shutdown_req) begin
          tHold = cyc;
        end
        if (allLocked) mArmed = 1;
      end else if (tProc < 0) begin
        if (proc1_idle) tProc = cyc;
        else if (cyc - tHold == HOLD_TIMEOUT) begin
          tProc = cyc;
          mTimeout = 1;
        end
      end else if (tRs < 0 && cyc > tProc + PROC_CNT) begin
        if (rs232_tx_idle) tRs = cyc;
        else if (cyc - (tProc + PROC_CNT) == DRAIN_TIMEOUT) begin
          tRs = cyc;
          mTimeout = 1;
        end
      end
      if (tRs >= 0) begin
        tClk = tRs + RS232_CNT;
        tAck = tClk + CLKGEN_CNT;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model while out of reset
  always @(negedge clk) begin
    if (reset_n) checkOutput("cycle_outputs", int'(dutVec()), int'(modelVec()));
  end

  initial begin
    // Reset state
    #1;
    checkOutput("reset_outputs", int'(dutVec()), 0);
    reset_n = 1'b1;

    // Orderly shutdown: hold, then proc reset 10 edges later, then drain completes on its first cycle
    doReset();
    applyStimulus(0, 1, 1, 0, 0, 3);
    applyStimulus(1, 1, 1, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 9);
    applyStimulus(0, 1, 1, 1, 0, 10);
    applyStimulus(0, 1, 1, 1, 1, 200);
    checkOutput("orderly_hold_to_proc", tProc - tHold, 10);
    checkOutput("orderly_proc_to_rs232", tRs - tProc, 17);
    checkOutput("orderly_rs232_to_clkgen", tClk - tRs, 64);
    checkOutput("orderly_clkgen_to_ack", tAck - tClk, 16);
    checkOutput("orderly_final_outputs", int'(dutVec()), 7'b1111100);

    // Hold and drain both time out
    doReset();
    applyStimulus(0, 1, 1, 0, 0, 3);
    applyStimulus(1, 1, 1, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 700);
    checkOutput("timeout_hold_to_proc", tProc - tHold, 255);
    checkOutput("timeout_proc_to_rs232", tRs - tProc, 271);
    checkOutput("timeout_final_outputs", int'(dutVec()), 7'b1111101);

    // Lock loss: three unlocked cycles do nothing, four trigger a teardown with no drain wait
    doReset();
    applyStimulus(0, 1, 1, 0, 0, 3);
    applyStimulus(0, 1, 0, 0, 0, 3);
    applyStimulus(0, 1, 1, 0, 0, 10);
    checkOutput("lock_glitch_ignored", int'(dutVec()), 0);
    applyStimulus(0, 1, 0, 0, 0, 4);
    checkOutput("lock_loss_outputs", int'(dutVec()), 7'b0100010);
    applyStimulus(0, 0, 0, 0, 0, 150);
    checkOutput("lock_proc_to_rs232", tRs - tProc, 16);
    checkOutput("lock_final_outputs", int'(dutVec()), 7'b0111110);

    // Unarmed: locks stay low for a long time, then rise, then drop
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1000);
    checkOutput("unarmed_quiet", int'(dutVec()), 0);
    applyStimulus(0, 1, 1, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 4);
    checkOutput("armed_lock_loss", int'(dutVec()), 7'b0100010);
    applyStimulus(0, 0, 0, 0, 0, 100);

    // Simultaneous request and lock loss, then async reset in the middle of RESET_RS232
    doReset();
    applyStimulus(0, 1, 1, 0, 0, 3);
    applyStimulus(0, 1, 0, 0, 0, 3);
    applyStimulus(1, 1, 0, 0, 0, 1);
    checkOutput("simul_hold_not_set", tHold, -1);
    applyStimulus(0, 1, 0, 0, 0, 21);
    checkOutput("simul_mid_rs232", int'(dutVec()), 7'b0110010);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", int'(dutVec()), 0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 20);
    checkOutput("post_reset_unarmed", int'(dutVec()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
